// File: rtl/btn_cond_pkg.sv
// btn_cond_pkg: shared FSM state type and default 100 MHz cycle counts for btn_cond.
package btn_cond_pkg;
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} btn_state_t;
    localparam int DEF_DEB_CYCLES = 1_000_000;
    localparam int DEF_RPT_DELAY  = 50_000_000;
    localparam int DEF_RPT_PERIOD = 20_000_000;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer plus stable-count debouncer producing the clean level.
module btn_debounce import btn_cond_pkg::*; #(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic s1, s2;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            if (s2 != level) begin
                if (cnt == CW'(DEB_CYCLES - 1)) begin
                    level <= s2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/btn_cond.sv
// btn_cond: debounced button level plus one-cycle advance pulses.
// Define BTN_COND_REPEAT_EN for hold-to-repeat; otherwise one pulse per press.
module btn_cond import btn_cond_pkg::*; #(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int RPT_DELAY  = DEF_RPT_DELAY,
    parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic pulse
);
    if (DEB_CYCLES < 1 || RPT_DELAY < 2 || RPT_PERIOD < 2) begin : g_bad_cfg
        $error("btn_cond: DEB_CYCLES must be >=1, RPT_DELAY/RPT_PERIOD >=2");
    end

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .level(level)
    );

    btn_state_t state, state_nx;
    logic pulse_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pulse <= 1'b0;
        end else begin
            state <= state_nx;
            pulse <= pulse_nx;
        end
    end

`ifdef BTN_COND_REPEAT_EN
    localparam int TMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int TW   = $clog2(TMAX + 1);
    logic [TW-1:0] tmr, tmr_nx;
    logic due;

    always_ff @(posedge clk) begin
        if (rst) tmr <= '0;
        else     tmr <= tmr_nx;
    end

    // tmr counts cycles since the last pulse; due fires on the cycle the next one is owed
    assign due = (state == HOLD)   ? (tmr == TW'(RPT_DELAY - 1)) :
                 (state == REPEAT) ? (tmr == TW'(RPT_PERIOD - 1)) : 1'b0;

    always_comb begin
        state_nx = state;
        pulse_nx = 1'b0;
        tmr_nx   = tmr;
        if (state == IDLE) begin
            if (level) begin
                state_nx = HOLD;
                pulse_nx = 1'b1;
                tmr_nx   = '0;
            end
        end else if (!level) begin
            state_nx = IDLE;
            tmr_nx   = '0;
        end else if (due) begin
            state_nx = REPEAT;
            pulse_nx = 1'b1;
            tmr_nx   = '0;
        end else if (tmr != TW'(TMAX)) begin
            tmr_nx = tmr + 1'b1;
        end
    end
`else
    always_comb begin
        state_nx = state;
        pulse_nx = 1'b0;
        if (state == IDLE && level) begin
            state_nx = HOLD;
            pulse_nx = 1'b1;
        end else if (state != IDLE && !level) begin
            state_nx = IDLE;
        end
    end
`endif
endmodule

// File: tb/tb_btn_cond.sv
// tb_btn_cond: directed scenarios plus random presses against a behavioural model of btn_cond.
module tb_btn_cond;
    localparam int DEB = 4;
    localparam int DLY = 20;
    localparam int PER = 8;
`ifdef BTN_COND_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;
    logic level, pulse;
    int checks = 0;
    int failures = 0;

    btn_cond #(.DEB_CYCLES(DEB), .RPT_DELAY(DLY), .RPT_PERIOD(PER)) dut (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .level(level),
        .pulse(pulse)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk_s(string name, string act, string exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual='%s' expected='%s'", name, act, exp);
        end
    endfunction

    function automatic string fmt(int q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
        return s;
    endfunction

    // Behavioural model: level flips once the synchronized input has shown the
    // other value for DEB consecutive edges; pulses at press and at t0+DLY+n*PER.
    int ecount = 0;
    int s0 = 0;
    int t0 = 0;
    bit p1, p2, d, mlevel, mpulse, active, same;
    bit win[$];

    always @(posedge clk) begin
        ecount++;
        if (rst) begin
            p1 = 0; p2 = 0; mlevel = 0; mpulse = 0; active = 0;
            win.delete();
        end else begin
            d = p2; p2 = p1; p1 = btn;
            mpulse = 0;
            if (!mlevel) active = 0;
            else if (!active) begin
                active = 1; t0 = ecount; mpulse = 1;
            end else if (REP && (ecount - t0) >= DLY && ((ecount - t0 - DLY) % PER) == 0)
                mpulse = 1;
            win.push_back(d);
            if (win.size() > DEB) void'(win.pop_front());
            if (win.size() == DEB) begin
                same = 1;
                foreach (win[i]) if (win[i] != win[0]) same = 0;
                if (same && win[0] != mlevel) mlevel = win[0];
            end
        end
    end

    int plog[$];
    bit saw_level = 0;
    bit prev_level = 0;
    int lrise = -1;
    int lfall = -1;
    logic prev_pulse = 1'b0;

    always @(negedge clk) begin
        chk("level", level, mlevel);
        chk("pulse", pulse, mpulse);
        if (pulse && prev_pulse) chk("pulse_back_to_back", 1, 0);
        prev_pulse = pulse;
        if (pulse) plog.push_back(ecount - s0);
        if (level) saw_level = 1;
        if (level && !prev_level) lrise = ecount - s0;
        if (!level && prev_level) lfall = ecount - s0;
        prev_level = level;
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clean_start();
        rst = 1; btn = 0;
        tick(2);
        rst = 0;
        tick(3);
        plog.delete();
        saw_level = 0; lrise = -1; lfall = -1;
        s0 = ecount;
    endtask

    initial begin
        // 1: reset with button held
        rst = 1; btn = 1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("rst_level", level, 0);
            chk("rst_pulse", pulse, 0);
        end
        // 2: short press
        clean_start();
        btn = 1; tick(10);
        btn = 0; tick(30);
        chk("s2_rise", lrise, 6);
        chk("s2_fall", lfall, 16);
        chk_s("s2_pulses", fmt(plog), "7 ");
        // 3: bounce shorter than the debounce window
        clean_start();
        for (int i = 0; i < 6; i++) begin
            btn = ~btn; tick(2);
        end
        btn = 0; tick(20);
        chk("s3_level_seen", saw_level, 0);
        chk("s3_npulses", plog.size(), 0);
        // 4/5: long hold
        clean_start();
        btn = 1; tick(60);
        btn = 0; tick(30);
        chk("s4_rise", lrise, 6);
        chk("s4_fall", lfall, 66);
        chk_s("s4_pulses", fmt(plog), REP ? "7 27 35 43 51 59 " : "7 ");
        // 6: reset mid-hold
        clean_start();
        btn = 1; tick(29);
        rst = 1; tick(1);
        chk("s6_rst_level", level, 0);
        chk("s6_rst_pulse", pulse, 0);
        rst = 0; tick(30);
        btn = 0; tick(30);
        chk("s6_rise", lrise, 36);
        chk("s6_fall", lfall, 66);
        chk_s("s6_pulses", fmt(plog), REP ? "7 27 37 57 65 " : "7 37 ");
        // random presses, bounces and resets
        clean_start();
        for (int i = 0; i < 300; i++) begin
            btn = 1'($urandom_range(0, 1));
            tick($urandom_range(1, 40));
            if ($urandom_range(0, 19) == 0) begin
                rst = 1; tick(1); rst = 0;
            end
        end
        btn = 0; tick(20);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/btn_cond.md
# btn_cond

Conditions one raw, bouncing push-button into a clean debounced level and single-cycle advance pulses, with optional hold-to-repeat. The digital clock top instantiates one per time-set button, between the board buttons and the clock core's hour/minute advance inputs. The seven-segment controller is the display output of that top; this block is its input side.

## Interface
- `DEB_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a level change; must be ≥1 (10 ms at 100 MHz).
- `RPT_DELAY`, default 50_000_000: cycles from the press pulse to the first repeat pulse; must be ≥2.
- `RPT_PERIOD`, default 20_000_000: cycles between later repeat pulses; must be ≥2.
- `clk` in 1: system clock; the block uses this single clock.
- `rst` in 1: synchronous, active-high reset.
- `btn` in 1: raw asynchronous button input, active-high.
- `level` out 1: debounced button level.
- `pulse` out 1: one-cycle advance strobe, registered.

## Operation
- Synchronizer: two flops `s1`→`s2`. Both reset to 0.
- Debounce runs on every edge where `s2 != level`:
  - If `cnt == DEB_CYCLES-1`, then `level <= s2` and `cnt <= 0`.
  - Otherwise `cnt <= cnt+1`.
- On any edge where `s2 == level`, `cnt <= 0`.
- FSM states: IDLE, HOLD, REPEAT. A timer `tmr` supports the FSM.
  - IDLE: on a rising edge of `level`, assert `pulse` for one cycle, load `tmr`, and go to HOLD.
  - HOLD: count `RPT_DELAY` cycles from the press pulse, then assert `pulse`, reload `tmr`, and go to REPEAT.
  - REPEAT: assert `pulse` every `RPT_PERIOD` cycles.
  - HOLD or REPEAT with `level`==0: go to IDLE and emit no pulse.
- Release and a due repeat on the same edge: release wins and no pulse is emitted.
- Reset, including in the middle of a hold: `s1`, `s2`, `level`, `cnt`, `tmr`, and `pulse` all clear to 0, and the state goes to IDLE.
  - If the button is still held after reset, this is a new press. It produces a fresh pulse after debounce.
- Width rules:
  - `cnt` is `$clog2(DEB_CYCLES+1)` bits.
  - `tmr` is `$clog2(max(RPT_DELAY,RPT_PERIOD)+1)` bits.
  - Counters saturate and never wrap.
- `level` falling never produces a pulse.

## Timing
- Reset values: `level`=0, `pulse`=0.
- Edge numbering: edge 1 is the first edge that samples `btn` high, with `btn` stable from then on.
- `level` rises at edge `DEB_CYCLES+2`.
- `pulse` is high for exactly the cycle after edge `DEB_CYCLES+3`.
- Release latency is symmetric: `level` falls `DEB_CYCLES+2` edges after the first low sample.
- Repeat pulses follow the press pulse by `RPT_DELAY` cycles, then by every further `RPT_PERIOD` cycles.
- `pulse` is never high on two consecutive cycles.

## Configuration
- `BTN_COND_REPEAT_EN` defined: the full IDLE/HOLD/REPEAT auto-repeat behaviour above applies.
- `BTN_COND_REPEAT_EN` undefined:
  - Exactly one pulse per debounced press, and HOLD waits for release.
  - The REPEAT state, the `tmr` counter, and the use of `RPT_DELAY`/`RPT_PERIOD` are removed. The parameters remain declared for port compatibility.

## Structure
- Package `btn_cond_pkg` holds:
  - the `btn_state_t` enum {IDLE, HOLD, REPEAT};
  - the default cycle-count constants for a 100 MHz clock.
- One sub-module, `btn_debounce` (synchronizer plus debounce counter), outputs `level`.
- The FSM and repeat timer live in `btn_cond`.

## Test plan
Bench parameters: DEB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=8, with the macro defined unless stated.

1. `rst` high for 3 cycles with `btn`=1 -> `level`=0 and `pulse`=0 throughout reset.
2. `btn` high from edge 1 for 10 cycles, then low -> `level` rises at edge 6; a single `pulse` after edge 7; `level` falls at edge 16; no further pulses.
3. `btn` toggling every 2 cycles for 12 cycles, then low -> `level` stays 0 and `pulse` stays 0.
4. `btn` held from edge 1 through edge 60 -> pulses after edges 7, 27, 35, 43, 51, 59. `level` falls at edge 66 and no pulse occurs at 67 (release wins).
5. Macro undefined, same stimulus as scenario 4 -> a single pulse after edge 7 only.
6. Stimulus as scenario 4, with `rst` pulsed at edge 30 while `btn` is held:
   - `pulse` and `level` are 0 after edge 30;
   - a new press pulse follows after edge 37;
   - the next repeat follows after edge 57.
